wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order pipeline write-back, taken from the MEM/WB register outputs;
  - a long-latency multiply/divide unit (MDU) that returns results out of band.
- MDU results are buffered in a small FIFO and drained in idle write-back slots.
- A starvation counter forces a drain slot by stalling the pipeline.
- Sits between the MEM/WB register, the MDU and the register file write port.

Parameters:
- FIFO_DEPTH, 2, number of buffered MDU results (power of two, minimum 2).
- STARVE_LIMIT, 4, consecutive denied cycles before the FIFO head is forced through (1..15).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- pipe_wb_en  input  1  pipeline requests a register write this cycle (RegWrite bit of WB_Out).
- pipe_dest  input  5  pipeline destination register.
- pipe_data  input  32  pipeline write data (already muxed ALU result / memory read).
- pipe_stall  output  1  combinational; freezes MEM/WB and earlier stages; pipeline re-presents identical inputs next cycle.
- mdu_valid  input  1  MDU result available.
- mdu_dest  input  5  MDU destination register.
- mdu_data  input  32  MDU result.
- mdu_ready  output  1  combinational; asserted when the FIFO is not full and rst=0.
- rf_we  output  1  registered register-file write enable.
- rf_dest  output  5  registered write address.
- rf_data  output  32  registered write data.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - While rst=1: rf_we=0, rf_dest=0, rf_data=0, FIFO empty, starve_cnt=0, mdu_ready=0, pipe_stall=0.
- Pipeline request definition:
  - pipe_req = pipe_wb_en and pipe_dest != 0. Writes to r0 are never issued.
- Enqueue:
  - Occurs when mdu_valid and mdu_ready.
  - An entry with mdu_dest=0 is accepted and then dropped; it is never enqueued.
  - No enqueue is allowed when full, even if a dequeue happens in the same cycle (mdu_ready depends only on full).
- Grant, evaluated each cycle:
  - force = FIFO non-empty and starve_cnt == STARVE_LIMIT.
  - If force: grant FIFO head, pipe_stall=1, pipeline write deferred.
  - Else if pipe_req: grant pipeline, pipe_stall=0.
  - Else if FIFO non-empty: grant FIFO head.
  - Else: no write.
- Output register:
  - On a grant, next cycle rf_we=1 and rf_dest/rf_data take the winner's values. Latency is exactly 1 cycle.
  - With no grant, rf_we=0 and rf_dest/rf_data hold their previous values.
- Dequeue:
  - Pops the FIFO head on a FIFO grant.
  - An entry enqueued in cycle N can be granted at the earliest in cycle N+1 (no bypass).
- Starvation counter starve_cnt:
  - Cleared on a FIFO grant, and when the FIFO is empty.
  - Incremented (saturating at STARVE_LIMIT) when the FIFO is non-empty and the pipeline wins.
- pipe_stall:
  - Asserted only in a force cycle, and only when pipe_req=1.
  - A force cycle with pipe_req=0 does not stall.
- FIFO:
  - Circular, with read/write pointers one bit wider than log2(FIFO_DEPTH).
  - full = same index and differing MSB; empty = pointers equal.
  - Pointers wrap naturally.
- Ordering:
  - RAW/WAW ordering between MDU and pipeline writes to the same register is the hazard unit's responsibility. This block does not reorder within a source; the FIFO is strict FIFO order.
- Reset mid-operation:
  - Buffered entries are discarded.
  - rf_we drops on the cycle after rst is sampled high.

Test Plan:
- Reset, then pipe_wb_en=1, pipe_dest=5, pipe_data=0x1234 for one cycle -> next cycle rf_we=1, rf_dest=5, rf_data=0x1234; pipe_stall=0 throughout.
- pipe_wb_en=1, pipe_dest=0 -> rf_we=0. Then mdu_valid with mdu_dest=0 -> accepted (mdu_ready=1), no write, FIFO stays empty.
- FIFO empty, pipeline idle; MDU result dest=9, data=0xCAFE in cycle N -> FIFO grant in N+1, rf_we=1, rf_dest=9, rf_data=0xCAFE in N+2.
- Continuous pipe_req (dest=3) plus one MDU result dest=7 -> pipeline wins 4 cycles (starve_cnt 1..4). On the 5th cycle pipe_stall=1 and the FIFO is granted; the next cycle shows rf_dest=7. The stalled pipeline write to r3 issues the following cycle.
- Hold pipeline busy and push 3 MDU results with FIFO_DEPTH=2 -> mdu_ready=0 after 2 accepts. The third is accepted only in the cycle after the first forced dequeue. Pointer wrap is verified by draining 5 results total in order 0x11..0x15.
- FIFO holding 2 entries, assert rst for 1 cycle -> rf_we=0 the next cycle, mdu_ready=1 after release, and no stale entries are ever written.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between the in-order
//            pipeline write-back and an out-of-band MDU. MDU results are
//            buffered in a small FIFO and drained in idle write-back slots.
//            A starvation counter forces a drain slot by stalling the
//            pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_en,
  input  logic [4:0]  pipe_dest,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_dest,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_data
);

  // Index width of the FIFO; pointers carry one extra wrap bit.
  localparam int         C_AW    = $clog2(FIFO_DEPTH);
  localparam int         C_PW    = C_AW + 1;
  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  // FIFO storage and pointers
  logic [36:0]     fifo_q [FIFO_DEPTH];
  logic [C_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PW-1:0] rd_ptr_q, rd_ptr_d;

  // Starvation counter and output register
  logic [3:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_dest_q, rf_dest_d;
  logic [31:0] rf_data_q, rf_data_d;

  // Combinational arbitration terms
  logic        w_pipe_req;
  logic        w_empty;
  logic        w_full;
  logic        w_force;
  logic        w_grant_fifo;
  logic        w_grant_pipe;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [36:0] w_head;

  assign w_pipe_req = pipe_wb_en && (pipe_dest != 5'd0);

  // Full when the indices match but the wrap bits differ.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[C_AW-1:0] == rd_ptr_q[C_AW-1:0]) &&
                   (wr_ptr_q[C_AW] != rd_ptr_q[C_AW]);

  assign w_force      = !w_empty && (starve_q == C_LIMIT);
  assign w_grant_fifo = w_force || (!w_pipe_req && !w_empty);
  assign w_grant_pipe = !w_force && w_pipe_req;

  // Ready depends only on full, so a same-cycle pop never opens a slot.
  assign mdu_ready  = !rst && !w_full;
  assign pipe_stall = !rst && w_force && w_pipe_req;

  // Results aimed at r0 are accepted but silently dropped.
  assign w_accept = mdu_valid && mdu_ready;
  assign w_push   = w_accept && (mdu_dest != 5'd0);
  assign w_pop    = w_grant_fifo;

  assign w_head = fifo_q[rd_ptr_q[C_AW-1:0]];

  // Pointer advance; pointers wrap naturally through the extra bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{C_AW{1'b0}}, w_push};
    rd_ptr_d = rd_ptr_q + {{C_AW{1'b0}}, w_pop};
  end

  // Starvation counter: counts pipeline wins while MDU data waits.
  always_comb begin
    starve_d = starve_q;
    if (w_empty || w_grant_fifo) begin
      starve_d = 4'd0;
    end else if (w_grant_pipe && (starve_q != C_LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Winner selection for the write port; address/data hold when idle.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_data_d = rf_data_q;
    if (w_grant_fifo) begin
      rf_we_d   = 1'b1;
      rf_dest_d = w_head[36:32];
      rf_data_d = w_head[31:0];
    end else if (w_grant_pipe) begin
      rf_we_d   = 1'b1;
      rf_dest_d = pipe_dest;
      rf_data_d = pipe_data;
    end
  end

  // FIFO payload storage; contents are qualified by the pointers only.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      fifo_q[wr_ptr_q[C_AW-1:0]] <= {mdu_dest, mdu_data};
    end
  end

  // Control state and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      starve_q  <= 4'd0;
      rf_we_q   <= 1'b0;
      rf_dest_q <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_dest_q <= rf_dest_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_dest = rf_dest_q;
  assign rf_data = rf_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter: directed scenarios
//            against hand-derived constants plus a randomized run against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_dest;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_dest;
  logic [31:0] rf_data;

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_wb_en(pipe_wb_en),
    .pipe_dest (pipe_dest),
    .pipe_data (pipe_data),
    .pipe_stall(pipe_stall),
    .mdu_valid (mdu_valid),
    .mdu_dest  (mdu_dest),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
    .rf_we     (rf_we),
    .rf_dest   (rf_dest),
    .rf_data   (rf_data)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending MDU results, a plain integer
  // starvation count, and the write the port should show after each edge.
  typedef struct packed {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  int          starve = 0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_dest = 5'd0;
  logic [31:0] m_data = 32'd0;

  function automatic bit model_ready();
    return !rst && (mq.size() < DEPTH);
  endfunction

  function automatic bit model_stall();
    return !rst && (mq.size() != 0) && (starve == LIMIT) &&
           pipe_wb_en && (pipe_dest != 5'd0);
  endfunction

  // Advance the model with the inputs present at this edge, then clock.
  task automatic tick();
    bit   req;
    bit   frc;
    bit   acc;
    ent_t e;
    req = pipe_wb_en && (pipe_dest != 5'd0);
    if (rst) begin
      mq.delete();
      starve = 0;
      m_we   = 1'b0;
      m_dest = 5'd0;
      m_data = 32'd0;
    end else begin
      frc = (mq.size() != 0) && (starve == LIMIT);
      acc = mdu_valid && (mq.size() < DEPTH);
      if (frc || (!req && mq.size() != 0)) begin
        e      = mq.pop_front();
        m_we   = 1'b1;
        m_dest = e.d;
        m_data = e.v;
        starve = 0;
      end else if (req) begin
        m_we   = 1'b1;
        m_dest = pipe_dest;
        m_data = pipe_data;
        starve = (mq.size() == 0) ? 0 : ((starve + 1 > LIMIT) ? LIMIT : starve + 1);
      end else begin
        m_we   = 1'b0;
        starve = 0;
      end
      if (acc && mdu_dest != 5'd0) begin
        e.d = mdu_dest;
        e.v = mdu_data;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wb_en = 1'b0;
    pipe_dest  = 5'd0;
    pipe_data  = 32'd0;
    mdu_valid  = 1'b0;
    mdu_dest   = 5'd0;
    mdu_data   = 32'd0;
  endtask

  task automatic pipe_busy(input logic [4:0] d, input logic [31:0] v);
    pipe_wb_en = 1'b1;
    pipe_dest  = d;
    pipe_data  = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    checks++; if (rf_dest !== 5'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", rf_dest); end
    checks++; if (rf_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", rf_data); end
    checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", mdu_ready); end
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", pipe_stall); end
    rst = 1'b0;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", mdu_ready); end
  endtask

  task automatic test_pipe_write();
    pipe_busy(5'd5, 32'h1234);
    #1;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL pipe_stall0 got=%b exp=0", pipe_stall); end
    tick();
    idle();
    #1;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL pipe_we got=%b exp=1", rf_we); end
    checks++; if (rf_dest !== 5'd5) begin failures++; $display("FAIL pipe_dest got=%0d exp=5", rf_dest); end
    checks++; if (rf_data !== 32'h1234) begin failures++; $display("FAIL pipe_data got=%h exp=1234", rf_data); end
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL pipe_stall1 got=%b exp=0", pipe_stall); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL pipe_we_off got=%b exp=0", rf_we); end
    checks++; if (rf_dest !== 5'd5) begin failures++; $display("FAIL pipe_dest_hold got=%0d exp=5", rf_dest); end
  endtask

  task automatic test_r0();
    pipe_busy(5'd0, 32'hFFFF);
    tick();
    idle();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_pipe_we got=%b exp=0", rf_we); end
    mdu_valid = 1'b1;
    mdu_dest  = 5'd0;
    mdu_data  = 32'hBEEF;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL r0_mdu_ready got=%b exp=1", mdu_ready); end
    tick();
    idle();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_mdu_we1 got=%b exp=0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_mdu_we2 got=%b exp=0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_mdu_we3 got=%b exp=0", rf_we); end
  endtask

  task automatic test_mdu_drain();
    mdu_valid = 1'b1;
    mdu_dest  = 5'd9;
    mdu_data  = 32'hCAFE;
    tick();
    idle();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL drain_nobypass got=%b exp=0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL drain_we got=%b exp=1", rf_we); end
    checks++; if (rf_dest !== 5'd9) begin failures++; $display("FAIL drain_dest got=%0d exp=9", rf_dest); end
    checks++; if (rf_data !== 32'hCAFE) begin failures++; $display("FAIL drain_data got=%h exp=cafe", rf_data); end
    tick();
  endtask

  task automatic test_starve();
    pipe_busy(5'd3, 32'h33);
    mdu_valid = 1'b1;
    mdu_dest  = 5'd7;
    mdu_data  = 32'h77;
    tick();
    mdu_valid = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL starve_nostall%0d got=%b exp=0", i, pipe_stall); end
      tick();
      checks++; if (rf_dest !== 5'd3) begin failures++; $display("FAIL starve_pipewin%0d got=%0d exp=3", i, rf_dest); end
    end
    #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL starve_force got=%b exp=1", pipe_stall); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 5'd7 || rf_data !== 32'h77) begin
      failures++; $display("FAIL starve_fifo got=%b/%0d/%h exp=1/7/77", rf_we, rf_dest, rf_data);
    end
    #1;
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL starve_release got=%b exp=0", pipe_stall); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 5'd3) begin
      failures++; $display("FAIL starve_replay got=%b/%0d exp=1/3", rf_we, rf_dest);
    end
    idle();
    tick();
  endtask

  task automatic test_full_wrap();
    int sent = 0;
    int got  = 0;
    bit acc;
    pipe_busy(5'd3, 32'h33);
    for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
      mdu_valid = (sent < 5);
      mdu_dest  = 5'(10 + sent);
      mdu_data  = 32'(32'h11 + sent);
      #1;
      if (cyc < 7) begin
        checks++;
        if (mdu_ready !== ((cyc < 2) || (cyc >= 6))) begin
          failures++; $display("FAIL full_ready cyc=%0d got=%b exp=%b", cyc, mdu_ready, (cyc < 2) || (cyc >= 6));
        end
      end
      acc = mdu_valid && mdu_ready;
      tick();
      if (acc) sent++;
      if (rf_we && rf_dest != 5'd3 && got < 5) begin
        checks++;
        if (rf_dest !== 5'(10 + got) || rf_data !== 32'(32'h11 + got)) begin
          failures++; $display("FAIL wrap_order idx=%0d got=%0d/%h exp=%0d/%h", got, rf_dest, rf_data, 10 + got, 32'h11 + got);
        end
        got++;
      end
    end
    checks++; if (got != 5) begin failures++; $display("FAIL wrap_count got=%0d exp=5", got); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    pipe_busy(5'd3, 32'h33);
    for (int i = 0; i < 2; i++) begin
      mdu_valid = 1'b1;
      mdu_dest  = 5'(20 + i);
      mdu_data  = 32'(32'hD0 + i);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rf_we !== 1'b0 || rf_dest !== 5'd0 || rf_data !== 32'd0) begin
      failures++; $display("FAIL rstmid_out got=%b/%0d/%h exp=0/0/0", rf_we, rf_dest, rf_data);
    end
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", mdu_ready); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rstmid_stale%0d got=%b exp=0", i, rf_we); end
    end
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        pipe_wb_en = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        pipe_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pipe_data  = $urandom;
      end
      mdu_valid = ($urandom_range(0, 2) == 0);
      mdu_dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdu_data  = $urandom;
      rst       = ($urandom_range(0, 79) == 0);
      #1;
      checks++; if (pipe_stall !== model_stall()) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, pipe_stall, model_stall()); end
      checks++; if (mdu_ready !== model_ready()) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, mdu_ready, model_ready()); end
      hold = model_stall();
      tick();
      checks++; if (rf_we !== m_we) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", i, rf_we, m_we); end
      checks++; if (rf_dest !== m_dest) begin failures++; $display("FAIL rnd_dest cyc=%0d got=%0d exp=%0d", i, rf_dest, m_dest); end
      checks++; if (rf_data !== m_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, rf_data, m_data); end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_pipe_write();
    test_r0();
    test_mdu_drain();
    test_starve();
    test_full_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
